// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types for the write buffer.
// Optional build macro used by write_buffer/wb_entry_array: WB_FORWARD_EN.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cline;
  typedef logic [11:0]  lc3b_line_tag;

  // Byte offset bits inside one 16-byte cache line.
  localparam int unsigned LINE_OFFSET_BITS = 4;

  // What the buffer decides to do with the request it sees while idle.
  typedef enum logic [2:0] {
    ACT_NONE     = 3'd0,  // nothing to do, stay idle
    ACT_ACK      = 3'd1,  // write absorbed (coalesce or enqueue), acknowledge
    ACT_FWD      = 3'd2,  // read served from a buffered line
    ACT_DRAIN    = 3'd3,  // push the head line out to memory
    ACT_MEM_READ = 3'd4   // fetch the requested line from memory
  } idle_action_t;

  // Line-aligned byte address of a line tag.
  function automatic lc3b_word line_base(input lc3b_line_tag tag);
    return {tag, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Circular store of buffered cache lines: valid bits, line tags, line data,
// tag-match vector and head/tail/count bookkeeping.
// With WB_FORWARD_EN defined an extra port exposes the data of the matching
// entry for read forwarding; without it no forwarding mux exists.
module wb_entry_array
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  lc3b_line_tag lookup_tag,
  input  logic         write_en,
  input  lc3b_cline    write_data,
  input  logic         pop,
  output logic         hit,
`ifdef WB_FORWARD_EN
  output lc3b_cline    hit_data,
`endif
  output lc3b_line_tag head_tag,
  output lc3b_cline    head_data,
  output logic         full,
  output logic         empty
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid;
  lc3b_line_tag     tags [DEPTH];
  lc3b_cline        data [DEPTH];
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] hit_idx;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // Tag compare against every valid entry; at most one entry can match
  // because a write to a buffered line always coalesces.
  always_comb begin
    match   = '0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (tags[i] == lookup_tag);
      if (match[i]) begin
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign hit       = |match;
  assign head_tag  = tags[head];
  assign head_data = data[head];
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);

`ifdef WB_FORWARD_EN
  assign hit_data = data[hit_idx];
`endif

  // Bookkeeping: enqueue at tail (unless coalescing) or retire the head.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (write_en) begin
      if (!hit) begin
        valid[tail] <= 1'b1;
        tags[tail]  <= lookup_tag;
        tail        <= tail + 1'b1;
        count       <= count + 1'b1;
      end
    end else if (pop) begin
      valid[head] <= 1'b0;
      head        <= head + 1'b1;
      count       <= count - 1'b1;
    end
  end

  // Line data storage; coalescing writes overwrite the matching entry.
  always_ff @(posedge clk) begin
    if (rst_n && write_en) begin
      if (hit) begin
        data[hit_idx] <= write_data;
      end else begin
        data[tail] <= write_data;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Write buffer between an L2 cache and physical memory. Line writes are
// absorbed into a small FIFO of lines (coalescing repeats to the same line)
// and drained to memory when the upstream side is quiet or the FIFO is full.
// Build macro WB_FORWARD_EN: reads that hit a buffered line are answered from
// the buffer; otherwise a read first drains the whole buffer, then reads memory.
//
// Handshake: every request (l2_read/l2_write, pmem_read/pmem_write) is held
// level-high by its initiator until the one-cycle resp pulse from the other
// side; the responder only samples requests in its accepting state.
module write_buffer
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  lc3b_word   l2_addr,
  input  logic       l2_read,
  input  logic       l2_write,
  input  lc3b_cline  l2_wdata,
  output logic       l2_resp,
  output lc3b_cline  l2_rdata,
  output lc3b_word   pmem_addr,
  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_cline  pmem_wdata,
  input  logic       pmem_resp,
  input  lc3b_cline  pmem_rdata,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_MEM_READ = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t       state;
  idle_action_t action;
  lc3b_line_tag req_tag;
  lc3b_line_tag head_tag;
  lc3b_cline    head_data;
  logic         hit;
  logic         full;
  logic         empty;
  logic         write_en;
  logic         pop;
  logic         unused_offset_bits;
`ifdef WB_FORWARD_EN
  lc3b_cline    hit_data;
`endif

  assign req_tag            = l2_addr[15:4];
  assign unused_offset_bits = ^l2_addr[3:0];
  assign fsm_state          = state;

  // The array is updated on the same edge the FSM leaves IDLE/DRAIN.
  assign write_en = (state == S_IDLE) && (action == ACT_ACK);
  assign pop      = (state == S_DRAIN) && pmem_resp;

  wb_entry_array #(
    .DEPTH(DEPTH)
  ) u_entries (
    .clk       (clk),
    .rst_n     (rst_n),
    .lookup_tag(req_tag),
    .write_en  (write_en),
    .write_data(l2_wdata),
    .pop       (pop),
    .hit       (hit),
`ifdef WB_FORWARD_EN
    .hit_data  (hit_data),
`endif
    .head_tag  (head_tag),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // Idle-state decision: reads beat writes, any request beats idle draining.
  always_comb begin
    action = ACT_NONE;
    if (l2_read) begin
`ifdef WB_FORWARD_EN
      action = hit ? ACT_FWD : ACT_MEM_READ;
`else
      action = empty ? ACT_MEM_READ : ACT_DRAIN;
`endif
    end else if (l2_write) begin
      action = (hit || !full) ? ACT_ACK : ACT_DRAIN;
    end else if (!empty) begin
      action = ACT_DRAIN;
    end
  end

  // Control FSM with registered memory-side and upstream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      l2_resp    <= 1'b0;
      l2_rdata   <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          case (action)
            ACT_ACK: begin
              l2_resp <= 1'b1;
              state   <= S_DONE;
            end
            ACT_FWD: begin
`ifdef WB_FORWARD_EN
              l2_rdata <= hit_data;
`endif
              l2_resp  <= 1'b1;
              state    <= S_DONE;
            end
            ACT_DRAIN: begin
              pmem_write <= 1'b1;
              pmem_addr  <= line_base(head_tag);
              pmem_wdata <= head_data;
              state      <= S_DRAIN;
            end
            ACT_MEM_READ: begin
              pmem_read <= 1'b1;
              pmem_addr <= line_base(req_tag);
              state     <= S_MEM_READ;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_DRAIN: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_MEM_READ: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            l2_rdata  <= pmem_rdata;
            l2_resp   <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          l2_resp <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer (DEPTH=4). Honours WB_FORWARD_EN when
// compiled with it. Memory is modelled as an associative array of lines;
// the reference model is "a read returns the most recent write to the line".
module tb_write_buffer;
  import lc3b_types::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0]  l2_addr = '0;
  logic         l2_read = 1'b0;
  logic         l2_write = 1'b0;
  logic [127:0] l2_wdata = '0;
  logic         l2_resp;
  logic [127:0] l2_rdata;
  logic [15:0]  pmem_addr;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [127:0] pmem_rdata = '0;
  logic [1:0]   fsm_state;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l2_addr   (l2_addr),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_wdata  (l2_wdata),
    .l2_resp   (l2_resp),
    .l2_rdata  (l2_rdata),
    .pmem_addr (pmem_addr),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata),
    .pmem_resp (pmem_resp),
    .pmem_rdata(pmem_rdata),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  int mem_delay = 1;
  int bad_cycles = 0;
  logic [127:0] mem [int];
  logic [127:0] model_mem [int];
  logic [143:0] wr_log[$];
  logic [15:0]  rd_log[$];
  logic [143:0] exp_q[$];

  function automatic logic [127:0] default_line(input logic [11:0] t);
    return {8{t, 4'h5}};
  endfunction

  function automatic void check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- memory model ----------------
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (cnt >= mem_delay) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            mem[int'(pmem_addr[15:4])] = pmem_wdata;
            wr_log.push_back({pmem_addr, pmem_wdata});
          end else begin
            pmem_rdata = mem.exists(int'(pmem_addr[15:4])) ? mem[int'(pmem_addr[15:4])]
                                                           : default_line(pmem_addr[15:4]);
            rd_log.push_back(pmem_addr);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Memory-side protocol monitor: never both requests, always line aligned.
  initial begin : proto_mon
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) bad_cycles++;
      if ((pmem_read || pmem_write) && (pmem_addr[3:0] != 4'h0)) bad_cycles++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit is_read, input logic [15:0] addr, input logic [127:0] wdata,
                        output int lat, output logic [127:0] rdata, output bit ok, output bit busy);
    l2_addr  = addr;
    l2_wdata = wdata;
    l2_read  = is_read;
    l2_write = !is_read;
    lat = 0; ok = 0; busy = 0; rdata = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (l2_resp) begin
        ok = 1; lat = i; rdata = l2_rdata; busy = pmem_read || pmem_write;
        break;
      end
    end
    @(posedge clk); #1;
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  task automatic expect_wr(input string name, input logic [15:0] a, input logic [127:0] d);
    bit seen;
    seen = 0;
    exp_q.push_back({a, d});
    for (int i = 0; i < 300; i++) begin
      if (wr_log.size() > 0) begin seen = 1; break; end
      @(negedge clk);
    end
    check({name, "_seen"}, seen, 1);
    if (seen) check(name, wr_log.pop_front(), exp_q.pop_front());
    else void'(exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic wait_drained();
    int quiet;
    bit done;
    quiet = 0; done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (fsm_state == 2'd0 && !pmem_write && !pmem_read) quiet++;
      else quiet = 0;
      if (quiet >= 4) done = 1;
    end
    check("drain_settle", done, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           is_read;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           exp_lat;    // -1: latency not checked
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    int lat;
    logic [127:0] rd;
    bit ok, busy;
    logic [127:0] da, db, dc;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_l2_resp", l2_resp, 0);
    check("rst_l2_rdata", l2_rdata, 0);
    check("rst_pmem_req", {pmem_read, pmem_write}, 0);
    check("rst_pmem_addr", pmem_addr, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_state", fsm_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // ---- single write, 1-cycle ack, later idle drain ----
    da = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    do_req(0, 16'h1230, da, lat, rd, ok, busy);
    check("a_ok", ok, 1);
    check("a_lat", lat, 1);
    check("a_no_pmem_at_resp", busy, 0);
    expect_wr("a_drain", 16'h1230, da);
    wait_drained();

    // ---- coalescing two writes to the same line ----
    db = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    do_req(0, 16'h1000, da, lat, rd, ok, busy);
    do_req(0, 16'h1008, db, lat, rd, ok, busy);
    check("b_lat", lat, 1);
    expect_wr("b_drain", 16'h1000, db);
    idle(10);
    check("b_single_drain", wr_log.size(), 0);
    wait_drained();

    // ---- full buffer, slow memory ----
    mem_delay = 3;
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      do_req(0, 16'h1000 + 16'(i * 16), {4{32'hC000_0000 + 32'(i)}}, lat, rd, ok, busy);
      check("c_fill_lat", lat, 1);
    end
    do_req(0, 16'h1040, {4{32'hC000_0004}}, lat, rd, ok, busy);
    check("c_5th_ok", ok, 1);
    check("c_5th_stalled", lat > 1, 1);
    check("c_head_before_5th", wr_log.size() >= 1, 1);
    for (int i = 0; i < 5; i++) begin
      expect_wr("c_order", 16'h1000 + 16'(i * 16), {4{32'hC000_0000 + 32'(i)}});
    end
    wait_drained();

    // ---- table-driven vectors ----
    mem_delay = 1;
    vecs[0] = '{0, 16'h4000, {4{32'hD1D1_D1D1}}, 1, '0};
    vecs[1] = '{0, 16'h4010, {4{32'hD2D2_D2D2}}, 1, '0};
    vecs[2] = '{0, 16'h4004, {4{32'hD3D3_D3D3}}, 1, '0};
`ifdef WB_FORWARD_EN
    vecs[3] = '{1, 16'h4000, '0, 1, {4{32'hD3D3_D3D3}}};
`else
    vecs[3] = '{1, 16'h4000, '0, -1, {4{32'hD3D3_D3D3}}};
`endif
    vecs[4] = '{1, 16'h5000, '0, -1, default_line(12'h500)};
    vecs[5] = '{0, 16'h401C, {4{32'hD4D4_D4D4}}, 1, '0};
    vecs[6] = '{1, 16'h4010, '0, -1, {4{32'hD4D4_D4D4}}};
    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].is_read, vecs[i].addr, vecs[i].wdata, lat, rd, ok, busy);
      check($sformatf("vec%0d_ok", i), ok, 1);
      if (vecs[i].exp_lat >= 0) check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].is_read) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    wait_drained();

    // ---- write then read the same line ----
    dc = 128'hCCCC_2000_CCCC_2000_CCCC_2000_CCCC_2000;
    wr_log.delete();
    rd_log.delete();
    do_req(0, 16'h2000, dc, lat, rd, ok, busy);
    do_req(1, 16'h2000, '0, lat, rd, ok, busy);
    check("d_rdata", rd, dc);
`ifdef WB_FORWARD_EN
    check("d_fwd_lat", lat, 1);
    check("d_no_pmem_read", rd_log.size(), 0);
    expect_wr("d_late_drain", 16'h2000, dc);
`else
    check("d_drained_first", wr_log.size(), 1);
    if (wr_log.size() > 0) check("d_drain_addr", wr_log[0][143:128], 16'h2000);
    check("d_pmem_read_cnt", rd_log.size(), 1);
    if (rd_log.size() > 0) check("d_pmem_read_addr", rd_log[0], 16'h2000);
`endif
    wait_drained();

    // ---- randomized traffic against "latest write wins" model ----
    model_mem[12'h200] = dc;
    for (int n = 0; n < 200; n++) begin
      logic [11:0] tag;
      logic [15:0] addr;
      logic [127:0] d;
      mem_delay = $urandom_range(0, 3);
      tag  = 12'h600 + 12'($urandom_range(0, 5));
      addr = {tag, 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 2) == 0) begin
        do_req(1, addr, '0, lat, rd, ok, busy);
        check("rand_rd_ok", ok, 1);
        check("rand_rd", rd, model_mem.exists(int'(tag)) ? model_mem[int'(tag)] : default_line(tag));
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
        do_req(0, addr, d, lat, rd, ok, busy);
        check("rand_wr_ok", ok, 1);
        model_mem[int'(tag)] = d;
      end
      idle($urandom_range(0, 3));
    end
    wait_drained();
    for (int t = 12'h600; t < 12'h606; t++) begin
      if (model_mem.exists(t)) check($sformatf("rand_mem_%0h", t), mem.exists(t) ? mem[t] : '0, model_mem[t]);
    end

    // ---- reset in the middle of a drain ----
    mem_delay = 10;
    do_req(0, 16'h3000, {4{32'hEEEE_3000}}, lat, rd, ok, busy);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_write) begin ok = 1; break; end
    end
    check("e_drain_started", ok, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("e_rst_pmem_write", pmem_write, 0);
    check("e_rst_l2_resp", l2_resp, 0);
    check("e_rst_state", fsm_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_delay = 1;
    wr_log.delete();
    rd_log.delete();
    idle(2);
    do_req(1, 16'h2000, '0, lat, rd, ok, busy);
    check("e_read_ok", ok, 1);
    check("e_read_data", rd, dc);
    check("e_no_flush", wr_log.size(), 0);
    check("e_pmem_read_cnt", rd_log.size(), 1);
    if (rd_log.size() > 0) check("e_pmem_read_addr", rd_log[0], 16'h2000);
    check("e_line_discarded", mem.exists(12'h300), 0);

    check("pmem_protocol", bad_cycles, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of cache-line entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port l2_addr  input  16 (lc3b_word)  upstream byte address; line address is l2_addr[15:4].
REQ-005 SHALL have port l2_read  input  1  upstream line read request, held until l2_resp.
REQ-006 SHALL have port l2_write  input  1  upstream line write request, held until l2_resp.
REQ-007 SHALL have port l2_wdata  input  128 (lc3b_cline)  upstream write line.
REQ-008 SHALL have port l2_resp  output  1  one-cycle completion pulse.
REQ-009 SHALL have port l2_rdata  output  128  read line, valid while l2_resp=1.
REQ-010 SHALL have port pmem_addr  output  16  memory address, bits [3:0]=0.
REQ-011 SHALL have ports pmem_read, pmem_write  output  1 each  memory requests, held until pmem_resp.
REQ-012 SHALL have port pmem_wdata  output  128  memory write line.
REQ-013 SHALL have ports pmem_resp  input  1 and pmem_rdata  input  128  memory completion and read line.

Function
REQ-014 SHALL implement states IDLE, DRAIN, MEM_READ, DONE.
REQ-015 IDLE, l2_write, line matches a valid entry: SHALL overwrite that entry's data (coalesce), go DONE.
REQ-016 IDLE, l2_write, no match, count<DEPTH: SHALL enqueue at tail, count+1, go DONE.
REQ-017 IDLE, l2_write, no match, count==DEPTH: SHALL go DRAIN; request re-evaluated on return to IDLE.
REQ-018 IDLE, l2_read, no match: SHALL go MEM_READ (see REQ-030 for match/forward behaviour).
REQ-019 IDLE, no request, count>0: SHALL go DRAIN; requests take priority over idle drain.
REQ-020 DRAIN: pmem_write=1, pmem_addr/pmem_wdata = head entry; on pmem_resp pop head, count-1, go IDLE.
REQ-021 MEM_READ: pmem_read=1, pmem_addr={l2_addr[15:4],4'b0}; on pmem_resp capture pmem_rdata into l2_rdata register, go DONE.
REQ-022 DONE: l2_resp=1 for exactly one cycle, then IDLE; l2_read/l2_write ignored in DONE.
REQ-023 Write latency: l2_resp SHALL assert the cycle after acceptance (1 cycle) when not full.
REQ-024 pmem_read and pmem_write SHALL never assert together; both 0 outside MEM_READ/DRAIN.
REQ-025 Head/tail pointers SHALL wrap modulo DEPTH; at most one valid entry per line address at any time.
REQ-026 Simultaneous l2_read and l2_write (protocol violation): read SHALL win.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state IDLE, count 0, pointers 0, all valid bits 0, l2_resp=0, l2_rdata=0, pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0.
REQ-028 Reset mid-DRAIN/MEM_READ SHALL abandon the transaction and discard buffered lines (no flush).

Configuration
REQ-029 Macro WB_FORWARD_EN SHALL select read forwarding.
REQ-030 Defined: IDLE l2_read matching a valid entry SHALL load that entry into l2_rdata, go DONE (1-cycle latency, no pmem access). Undefined: IDLE l2_read with count>0 SHALL go DRAIN (repeat until empty), then MEM_READ; no forwarding logic present.

Structure
REQ-031 lc3b_types SHALL hold lc3b_word, lc3b_cline and new lc3b_line_tag (12 bits); state enum local to module.
REQ-032 Entry storage (valid, tag, data, tag-match vector, head/tail/count) SHALL be sub-module wb_entry_array; FSM and muxing stay in write_buffer.

Verification
REQ-033 Write 0x1230 data A, DEPTH=4 -> l2_resp next cycle, no pmem access that cycle; later idle -> pmem_write addr 0x1230 data A.
REQ-034 Writes 0x1000 A then 0x1008 B, no idle gap -> single entry, drained once with data B.
REQ-035 Five distinct-line writes with pmem_resp delayed 3 cycles -> fifth write's l2_resp only after head (first line) written to pmem.
REQ-036 WB_FORWARD_EN: write 0x2000 C then read 0x2000 -> l2_rdata=C one cycle later, pmem_read never asserted; without macro -> drain 0x2000 first, then pmem_read 0x2000.
REQ-037 rst_n=0 during DRAIN -> next cycle pmem_write=0, l2_resp=0, count 0; subsequent read 0x2000 goes to pmem.
